binary_div_seq_bi: RTL and testbench

- Sequential signed restoring divider; the inverse-direction companion to the team's signed binary multiplier.
- Accepts a signed dividend/divisor pair on a start pulse and iterates one quotient bit per clock.
- Returns a signed quotient and remainder using truncate-toward-zero semantics, identical to Verilog signed `/` and `%`.
- Sits beside the multiplier in the arithmetic datapath and is checked against it with a multiply-back test (Q*B+R == A).

---
 rtl/binary_div_seq_bi.sv | 164 ++++++++++++++++
 tb/tb_binary_div_seq_bi.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/binary_div_seq_bi.sv
// Sequential signed restoring divider, one quotient bit per clock, truncating toward zero.
// Optional divide-by-zero short path enabled by defining DIV_ZERO_CHECK_EN.
module binary_div_seq_bi #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH:0]   r_bmag;
  logic             r_sa;
  logic             r_sq;
  logic             r_ovf_pend;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_done;
  logic             r_ovf;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH:0]   w_b_mag;
  logic             w_a_min;
  logic             w_b_m1;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_a_mag   = A[WIDTH-1] ? -A : A;
  assign w_b_mag   = {1'b0, (B[WIDTH-1] ? -B : B)};
  assign w_a_min   = (A == {1'b1, {(WIDTH-1){1'b0}}});
  assign w_b_m1    = (B == {WIDTH{1'b1}});

  // The true difference is always below 2^(WIDTH-1), so the top bit can be dropped.
  assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= r_bmag);
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_bmag[WIDTH-1:0];
  assign w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];

  // r_dvd holds the quotient magnitude after CALC, or |A| untouched on the zero-divisor path.
  assign w_q_fix   = r_sq ? -r_dvd : r_dvd;
  assign w_r_fix   = r_sa ? -r_rem : r_rem;

`ifdef DIV_ZERO_CHECK_EN
  logic w_b_zero;
  logic r_dz_pend;
  logic r_dz;
  assign w_b_zero = (B == {WIDTH{1'b0}});
  assign dz       = r_dz;
`else
  assign dz       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_CALC;
`ifdef DIV_ZERO_CHECK_EN
          if (w_b_zero) w_state_nx = S_FIX;
`endif
        end
      end
      S_CALC:  if (r_cnt == '0) w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_dvd      <= '0;
      r_bmag     <= '0;
      r_sa       <= 1'b0;
      r_sq       <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      r_dz_pend  <= 1'b0;
      r_dz       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dvd      <= w_a_mag;
            r_bmag     <= w_b_mag;
            r_rem      <= '0;
            r_sa       <= A[WIDTH-1];
            r_sq       <= A[WIDTH-1] ^ B[WIDTH-1];
            r_cnt      <= CNT_LAST;
            r_ovf_pend <= w_a_min & w_b_m1;
`ifdef DIV_ZERO_CHECK_EN
            r_dz_pend  <= w_b_zero;
`endif
          end
        end
        S_CALC: begin
          r_rem <= w_rem_nx;
          r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_done <= 1'b1;
          r_q    <= w_q_fix;
          r_r    <= w_r_fix;
          r_ovf  <= r_ovf_pend;
`ifdef DIV_ZERO_CHECK_EN
          r_dz   <= r_dz_pend;
          if (r_dz_pend) begin
            // Divisor sign is positive here, so w_q_fix reconstructs A.
            r_q   <= {WIDTH{1'b1}};
            r_r   <= w_q_fix;
            r_ovf <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign done = r_done;
  assign ovf  = r_ovf;
  assign busy = (r_state == S_CALC) || (r_state == S_FIX);

endmodule

// File: tb/tb_binary_div_seq_bi.sv
// Directed and exhaustive self-checking bench for binary_div_seq_bi at WIDTH=4.
module tb_binary_div_seq_bi;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       ovf;
  logic       dz;

  int n_total = 0;
  int n_bad   = 0;

  binary_div_seq_bi #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .ovf(ovf), .dz(dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic issue(input int a, input int b);
    @(negedge clk);
    A = a[3:0];
    B = b[3:0];
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic op(input int a, input int b, input int eq, input int er, input int eovf);
    int lat;
    issue(a, b);
    wait_done(lat);
    chk("latency", lat, 5);
    chk("q", int'($signed(Q)), eq);
    chk("r", int'($signed(R)), er);
    chk("ovf", int'(ovf), eovf);
    chk("dz", int'(dz), 0);
  endtask

  initial begin
    int lat;
    int qv, rv, mb;
    int av[$];
    int bv[$];

    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    #2 rst = 1'b1;
    #3;
    chk("rst_q", int'(Q), 0);
    chk("rst_r", int'(R), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_dz", int'(dz), 0);
    @(negedge clk);
    rst = 1'b0;

    op(7, 2, 3, 1, 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(done), 0);
    chk("q_hold", int'($signed(Q)), 3);
    op(-7, 2, -3, -1, 0);
    op(7, -2, -3, 1, 0);
    op(-7, -2, 3, -1, 0);
    op(-8, -1, -8, 0, 1);
    op(-8, 1, -8, 0, 0);

`ifdef DIV_ZERO_CHECK_EN
    issue(5, 0);
    wait_done(lat);
    chk("dz_latency", lat, 1);
    chk("dz_q", int'($signed(Q)), -1);
    chk("dz_r", int'($signed(R)), 5);
    chk("dz_flag", int'(dz), 1);
    chk("dz_ovf", int'(ovf), 0);
    op(6, 3, 2, 0, 0);
`endif

    // Reset in the middle of an operation must abort it and clear outputs at once.
    issue(7, 3);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q", int'(Q), 0);
    chk("midrst_r", int'(R), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) lat++;
    end
    chk("midrst_no_done", lat, 0);
    op(6, -4, -1, 2, 0);

    for (int a = -8; a <= 7; a++)
      for (int b = -8; b <= 7; b++)
        if (b != 0) begin
          av.push_back(a);
          bv.push_back(b);
        end

    // Back-to-back: start stays high so each done cycle accepts the next pair.
    @(negedge clk);
    A = av[0][3:0];
    B = bv[0][3:0];
    start = 1'b1;
    for (int i = 0; i < av.size(); i++) begin
      @(posedge clk); #1;
      chk("b2b_busy", int'(busy), 1);
      if (i + 1 < av.size()) begin
        A = av[i+1][3:0];
        B = bv[i+1][3:0];
      end else begin
        start = 1'b0;
      end
      wait_done(lat);
      chk("b2b_latency", lat, 5);
      qv = av[i] / bv[i];
      rv = av[i] % bv[i];
      if (qv > 7) qv -= 16;
      chk("ex_q", int'($signed(Q)), qv);
      chk("ex_r", int'($signed(R)), rv);
      chk("ex_ovf", int'(ovf), (av[i] == -8 && bv[i] == -1) ? 1 : 0);
      mb = int'($signed(Q)) * bv[i] + int'($signed(R));
      chk("ex_mulback", mb & 15, av[i] & 15);
    end

    @(posedge clk); #1;
    chk("final_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
